// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// length-field width and the capacity check.
package imem_loader_pkg;

  localparam int LEN_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // A length of exactly 2^aw words is legal; one more is not.
  function automatic logic len_fits(input logic [LEN_W-1:0] n, input int unsigned aw);
    return {16'd0, n} <= (32'd1 << aw);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses
// the cycle after the fourth byte of each word is accepted.
module imem_loader_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] word_q, word_d;
  logic        wv_q, wv_d;

  always_comb begin
    idx_d  = idx_q;
    sh_d   = sh_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      // Bytes shift in from the top, so after three the first sits in [7:0].
      if (idx_q == 2'd3) begin
        word_d = {byte_data, sh_q};
        wv_d   = 1'b1;
      end else begin
        sh_d = {byte_data, sh_q[23:8]};
      end
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 2'd0;
      sh_q   <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

  assign byte_idx   = idx_q;
  assign word_valid = wv_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes words into
// instruction memory and holds the CPU in reset while a load is in flight.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  rcvd_q, rcvd_d;
  logic [CNT_W-1:0]  loaded_q, loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              accept, data_byte, asm_clear, word_valid;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic [LEN_W-1:0]  len_in;

  assign len_in = {rx_data, len_lo_q};

  // Stop accepting once every word's bytes are in; the final write drains after.
  assign rx_ready  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     ((state_q == ST_DATA) && (LEN_W'(rcvd_q) < len_q));
  assign accept    = rx_valid && rx_ready;
  assign data_byte = accept && (state_q == ST_DATA);

  imem_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    rcvd_d    = rcvd_q;
    loaded_d  = loaded_q;
    addr_d    = addr_q;
    err_d     = err_q;
    cpu_rst_d = cpu_rst_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LEN_LO;
          err_d     = 1'b0;
          loaded_d  = '0;
          cpu_rst_d = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_in;
          if (len_in == '0) begin
            state_d = ST_FINISH;
          end else if (!len_fits(len_in, ADDR_W)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            rcvd_d    = '0;
            addr_d    = '0;
            asm_clear = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // Address latched with the word, so it never steps past the last slot.
        if (data_byte && (byte_idx == 2'd3)) begin
          addr_d = rcvd_q[ADDR_W-1:0];
          rcvd_d = rcvd_q + CNT_W'(1);
        end
        if (word_valid) begin
          loaded_d = loaded_q + CNT_W'(1);
          if (LEN_W'(loaded_q) + LEN_W'(1) == len_q)
            state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        cpu_rst_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      rcvd_q    <= '0;
      loaded_q  <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= BOOT_HOLD;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      rcvd_q    <= rcvd_d;
      loaded_q  <= loaded_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign imem_we      = word_valid;
  assign imem_wdata   = word;
  assign imem_addr    = addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH);
  assign err          = err_q;
  assign cpu_reset    = cpu_rst_q;
  assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are queued
// from a stream-level model and retired by a monitor on the falling edge.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, imem_we, cpu_reset, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [39:0] exp_wr[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Reference: a stream is N (LE16) then N little-endian words, written to 0..N-1.
  task automatic model(input logic [7:0] q[$]);
    int n;
    n = int'(q[0]) | (int'(q[1]) << 8);
    if (n <= CAP)
      for (int i = 0; i < n; i++)
        exp_wr.push_back({8'(i), q[2+4*i+3], q[2+4*i+2], q[2+4*i+1], q[2+4*i]});
  endtask

  task automatic feed(input logic [7:0] q[$], input int gap_mode, input int start_at);
    for (int i = 0; i < q.size(); i++) begin
      int budget;
      bit taken;
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) cyc();
      rx_valid = 1'b1;
      rx_data  = q[i];
      if (i == start_at) start = 1'b1;
      budget = 0;
      taken  = 1'b0;
      while (!taken && budget < 50) begin
        @(negedge clk);
        taken = rx_valid && rx_ready;
        cyc();
        start = 1'b0;
        budget++;
      end
      if (!taken) chk("byte_accept_timeout", 64'(i), 64'hFFFF);
      rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("start_err_clr", 64'(err), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("start_words_clr", 64'(words_loaded), 64'd0);
    cyc();
  endtask

  task automatic run_session(input logic [7:0] q[$], input int gap_mode, input int start_at);
    int n;
    int d0;
    int budget;
    n  = int'(q[0]) | (int'(q[1]) << 8);
    d0 = done_cnt;
    model(q);
    pulse_start();
    feed(q, gap_mode, start_at);
    budget = 0;
    while (busy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    chk("session_idle", 64'(busy), 64'd0);
    if (n > CAP) begin
      chk("ovf_err", 64'(err), 64'd1);
      chk("ovf_no_done", 64'(done_cnt - d0), 64'd0);
      chk("ovf_words", 64'(words_loaded), 64'd0);
      chk("ovf_cpu_reset", 64'(cpu_reset), 64'd1);
    end else begin
      chk("done_once", 64'(done_cnt - d0), 64'd1);
      chk("words_loaded", 64'(words_loaded), 64'(n));
      chk("no_err", 64'(err), 64'd0);
      chk("cpu_released", 64'(cpu_reset), 64'd0);
    end
    chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    cyc();
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({nm, "_we"}, 64'(imem_we), 64'd0);
    chk({nm, "_addr"}, 64'(imem_addr), 64'd0);
    chk({nm, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'd0);
    chk({nm, "_words"}, 64'(words_loaded), 64'd0);
    chk({nm, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
  endtask

  task automatic monitor();
    logic [39:0] e;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {24'd0, 8'(imem_addr), imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(imem_addr), 64'(e[39:32]));
          chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
        end
      end
      if (prev_done) chk("cpu_reset_after_done", 64'(cpu_reset), 64'd0);
      if (done) begin
        done_cnt++;
        chk("cpu_reset_at_done", 64'(cpu_reset), 64'd1);
      end
      if (busy && !cpu_reset) chk("cpu_reset_held", 64'(cpu_reset), 64'd1);
      if (!busy && rx_ready) chk("idle_rx_ready", 64'(rx_ready), 64'd0);
      prev_done = done && reset;
    end
  endtask

  task automatic stimulus();
    logic [7:0] q[$];
    logic [7:0] r[$];
    int d0;

    @(negedge clk);
    check_reset_vals("por");
    cyc();
    reset = 1'b1;
    cyc();

    // Bytes offered while idle must sit unconsumed.
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (4) cyc();
    rx_valid = 1'b0;
    chk("idle_ignore_rx", 64'(busy), 64'd0);

    q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00};
    run_session(q, 0, -1);
    run_session(q, 1, -1);
    q = '{8'h00, 8'h00};
    run_session(q, 2, -1);
    q = '{8'h01, 8'h01};
    run_session(q, 0, -1);
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_session(q, 0, -1);

    // Abort mid-session: word 0 lands, the rest is lost, no done.
    q = '{8'h03, 8'h00};
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    exp_wr.push_back({8'd0, q[5], q[4], q[3], q[2]});
    d0 = done_cnt;
    pulse_start();
    r = q[0:6];
    feed(r, 2, -1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("abort");
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_writes", 64'(exp_wr.size()), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    run_session(q, 0, -1);

    // start during DATA is ignored.
    q = '{8'h03, 8'h00};
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    run_session(q, 0, 5);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 8));
      q = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      run_session(q, int'($urandom_range(0, 2)), (k % 2 == 1) ? int'($urandom_range(2, 4 * n)) : -1);
    end

    // Full capacity: last address written once, no wrap.
    q = '{8'h00, 8'h01};
    for (int i = 0; i < 4 * CAP; i++) q.push_back(8'($urandom));
    run_session(q, 0, -1);
    chk("cap_addr_last", 64'(imem_addr), 64'(CAP - 1));
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #1_000_000;
        chk("global_timeout", 64'd1, 64'd0);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 Parameter BOOT_HOLD, default 1, 1 = hold CPU in reset from system reset until the first successful load.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 rx_valid  input  1  byte stream valid.
REQ-007 rx_data  input  8  byte stream data.
REQ-008 rx_ready  output  1  loader accepts byte; transfer when rx_valid & rx_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  word address of write.
REQ-011 imem_wdata  output  32  instruction word.
REQ-012 cpu_reset  output  1  active-high reset driven to the CPU core.
REQ-013 busy  output  1  load session in progress.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 err  output  1  sticky; length exceeds capacity; cleared by next start.
REQ-016 words_loaded  output  ADDR_W+1  count of words written in current/last session.

Function
REQ-017 Stream format SHALL be: 16-bit word count N (low byte first), then 4*N bytes, each word little-endian (first byte = bits 7:0).
REQ-018 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, FINISH.
REQ-019 IDLE: rx_ready=0, busy=0; start moves to LEN_LO next cycle, clears err and words_loaded, asserts cpu_reset.
REQ-020 LEN_LO/LEN_HI: rx_ready=1; each accepted byte captured and state advances; no advance without handshake.
REQ-021 After LEN_HI handshake: N=0 -> FINISH; N>2^ADDR_W -> err=1, IDLE, no writes, cpu_reset remains 1; else DATA with byte index 0, address 0.
REQ-022 DATA: rx_ready=1; byte index counts 0..3 with wrap; on 4th byte accepted, imem_we=1 the next cycle with the assembled word and current address; address and words_loaded then increment.
REQ-023 Back-to-back bytes every cycle SHALL be sustained with no stall; a write cycle SHALL overlap acceptance of the next word's bytes.
REQ-024 After the Nth word's write cycle the FSM SHALL enter FINISH; FINISH lasts one cycle: done=1, cpu_reset deasserts the following cycle, return to IDLE.
REQ-025 start while busy SHALL be ignored; rx_valid in IDLE SHALL be ignored (not consumed).
REQ-026 busy=1 in every state except IDLE.
REQ-027 imem_addr SHALL never exceed 2^ADDR_W-1; N=2^ADDR_W writes the last address exactly once with no wrap.
REQ-028 cpu_reset SHALL stay asserted continuously from start through the FINISH cycle inclusive.
REQ-029 With BOOT_HOLD=0, cpu_reset SHALL be 0 after system reset until a start.

Reset
REQ-030 On reset low: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, words_loaded=0, cpu_reset=BOOT_HOLD.
REQ-031 Reset mid-session SHALL abort immediately; partially written memory is not rolled back; no done pulse.

Structure
REQ-032 State encoding and the length-field width (16) SHALL live in the shared CPU package.
REQ-033 A sub-module byte_assembler (4-byte little-endian shift/pack with index counter and word_valid) is the natural split; FSM and counters stay in imem_loader.

Verification
REQ-034 Load N=2: bytes 02 00 93 00 50 00 13 01 30 00 -> writes addr0=0x00500093, addr1=0x00300113, done pulse once, words_loaded=2, cpu_reset falls one cycle after done.
REQ-035 Same stream with rx_valid toggling every other cycle -> identical writes, no lost or duplicated bytes.
REQ-036 N=0 (00 00) -> no imem_we, done pulse, words_loaded=0.
REQ-037 ADDR_W=8, N=257 (01 01) -> err=1, zero writes, IDLE, cpu_reset=1; next start clears err.
REQ-038 Reset asserted after 5 data bytes -> all outputs at reset values next cycle, no done; re-load succeeds.
REQ-039 start pulsed during DATA -> ignored, session completes normally.
